// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: default widths, opcode map and class encodings.
// The classify() helper maps an opcode onto its class and immediate extension mode.
package decode_stage_pkg;

    localparam int DEF_INSTR_WIDTH = 16;
    localparam int DEF_OPCODE_W    = 4;
    localparam int DEF_REG_ADDR_W  = 4;
    localparam int DEF_DATA_WIDTH  = 16;

    localparam int unsigned OP_NOP   = 0;
    localparam int unsigned OP_ADD   = 1;
    localparam int unsigned OP_SUB   = 2;
    localparam int unsigned OP_MUL   = 3;
    localparam int unsigned OP_DIV   = 4;
    localparam int unsigned OP_CONST = 5;
    localparam int unsigned OP_LDR   = 6;
    localparam int unsigned OP_STR   = 7;
    localparam int unsigned OP_BR    = 8;
    localparam int unsigned OP_CMP   = 9;
    localparam int unsigned OP_RET   = 15;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LDI     = 3'd2,
        CLS_MEM     = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_RET     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_e;

    typedef enum logic [1:0] {
        EXT_ZERO,
        EXT_SIGN,
        EXT_CLEAR
    } imm_ext_e;

    typedef struct packed {
        instr_class_e cls;
        imm_ext_e     ext;
    } class_info_t;

    function automatic class_info_t classify(input logic [31:0] op);
        class_info_t info;
        info.cls = CLS_ILLEGAL;
        info.ext = EXT_CLEAR;
        case (op)
            OP_NOP:                                  begin info.cls = CLS_NOP;    info.ext = EXT_ZERO; end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP:  begin info.cls = CLS_ALU;    info.ext = EXT_ZERO; end
            OP_CONST:                                begin info.cls = CLS_LDI;    info.ext = EXT_ZERO; end
            OP_LDR, OP_STR:                          begin info.cls = CLS_MEM;    info.ext = EXT_ZERO; end
            OP_BR:                                   begin info.cls = CLS_BRANCH; info.ext = EXT_SIGN; end
            OP_RET:                                  begin info.cls = CLS_RET;    info.ext = EXT_ZERO; end
            default:                                 begin info.cls = CLS_ILLEGAL; info.ext = EXT_CLEAR; end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: one output register plus one skid register,
// registered in_ready, full throughput, flush drops everything held.
module decode_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             accept;
    logic             out_free;
    logic             out_valid_nxt;
    logic             skid_valid_nxt;
    logic             load_skid;
    logic [WIDTH-1:0] out_data_nxt;

    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;

    always_comb begin
        out_valid_nxt  = out_valid;
        skid_valid_nxt = skid_valid;
        out_data_nxt   = out_data;
        load_skid      = 1'b0;
        if (out_free) begin
            if (skid_valid) begin
                out_valid_nxt  = 1'b1;
                out_data_nxt   = skid_data;
                skid_valid_nxt = 1'b0;
            end else if (accept) begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = in_data;
            end else begin
                out_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            skid_valid_nxt = 1'b1;
            load_skid      = 1'b1;
        end
        if (flush) begin
            out_valid_nxt  = 1'b0;
            skid_valid_nxt = 1'b0;
            out_data_nxt   = out_data;
            load_skid      = 1'b0;
        end
    end

    // NOTE: in_ready is registered from the next skid state, so it never combinationally depends on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else begin
            out_valid  <= out_valid_nxt;
            skid_valid <= skid_valid_nxt;
            in_ready   <= !skid_valid_nxt;
            out_data   <= out_data_nxt;
            if (load_skid) skid_data <= in_data;
        end
    end

    hold_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: rtl/decode_stage.sv
// Registered instruction decode stage: field split, classification, immediate extension.
// Optional performance counters are built when DECODE_PERF_CNT_EN is defined.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int OPCODE_W    = DEF_OPCODE_W,
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPCODE_W-1:0]    opcode,
    output logic [REG_ADDR_W-1:0]  dest_reg,
    output logic [REG_ADDR_W-1:0]  src1_reg,
    output logic [REG_ADDR_W-1:0]  src2_reg,
    output logic [DATA_WIDTH-1:0]  immediate,
    output logic [2:0]             instr_class,
    output logic                   illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]            perf_decoded,
    output logic [31:0]            perf_stall,
    output logic [15:0]            perf_illegal
`endif
);

    localparam int IMM_W = INSTR_WIDTH - OPCODE_W - REG_ADDR_W;
    localparam int PAY_W = OPCODE_W + 3 * REG_ADDR_W + DATA_WIDTH + 3 + 1;

    logic [OPCODE_W-1:0]   d_opcode;
    logic [REG_ADDR_W-1:0] d_dest;
    logic [REG_ADDR_W-1:0] d_src1;
    logic [REG_ADDR_W-1:0] d_src2;
    logic [IMM_W-1:0]      d_imm_raw;
    logic [DATA_WIDTH-1:0] d_imm;
    class_info_t           d_info;
    logic [PAY_W-1:0]      pay_in;
    logic [PAY_W-1:0]      pay_out;

    assign d_opcode  = instruction[INSTR_WIDTH-1 -: OPCODE_W];
    assign d_dest    = instruction[INSTR_WIDTH-OPCODE_W-1 -: REG_ADDR_W];
    assign d_src1    = instruction[INSTR_WIDTH-OPCODE_W-REG_ADDR_W-1 -: REG_ADDR_W];
    assign d_src2    = instruction[REG_ADDR_W-1:0];
    assign d_imm_raw = instruction[IMM_W-1:0];
    assign d_info    = classify(32'(d_opcode));

    always_comb begin
        d_imm = '0;
        case (d_info.ext)
            EXT_ZERO: d_imm = DATA_WIDTH'(d_imm_raw);
            EXT_SIGN: d_imm = DATA_WIDTH'($signed(d_imm_raw));
            default:  d_imm = '0;
        endcase
    end

    // Decoded fields travel through the buffer as one flat payload word.
    assign pay_in = {d_opcode, d_dest, d_src1, d_src2, d_imm, d_info.cls, d_info.cls == CLS_ILLEGAL};
    assign {opcode, dest_reg, src1_reg, src2_reg, immediate, instr_class, illegal} = pay_out;

    decode_skid_buf #(
        .WIDTH(PAY_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (pay_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (pay_out)
    );

`ifdef DECODE_PERF_CNT_EN
    logic xfer;
    logic stall;

    assign xfer  = out_valid && out_ready;
    assign stall = out_valid && !out_ready;

    // Counters saturate and survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_decoded <= '0;
            perf_stall   <= '0;
            perf_illegal <= '0;
        end else begin
            if (xfer && perf_decoded != '1) perf_decoded <= perf_decoded + 32'd1;
            if (stall && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
            if (xfer && illegal && perf_illegal != '1) perf_illegal <= perf_illegal + 16'd1;
        end
    end
`endif

endmodule
